// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg
//   Shared types and constants for the simple-bus arbiter slice:
//   FSM state encoding, master index constants, access-size codes and a
//   default-width request bundle for code that uses 32-bit buses.
package simple_bus_pkg;

  // FSM states; explicit encodings keep legacy code that compares raw
  // 2-bit values working.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Master indices
  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  // Access-size codes carried on req_size / mem_size
  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  // Default bus widths and the matching request bundle
  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic                  writeEn;
    logic [2:0]            size;
    logic [BUS_DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/simple_bus_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way picker.
//   req_i[1:0]    : request vector (bit 0 = m0, bit 1 = m1)
//   last_i        : index of the master granted most recently
//   rr_en_i       : 1 = round-robin on a tie, 0 = m1 wins every tie
//   grant_o       : index of the chosen master
//   grant_valid_o : 1 when at least one master is requesting
module rr_pick2
  import simple_bus_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       rr_en_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  // Pick the winner; on a tie round-robin favours whoever was not last.
  always_comb begin
    grant_o       = M_IFU;
    grant_valid_o = |req_i;
    case (req_i)
      2'b01:   grant_o = M_IFU;
      2'b10:   grant_o = M_LSU;
      2'b11: begin
        if (rr_en_i) begin
          grant_o = ~last_i;
        end else begin
          grant_o = M_LSU;
        end
      end
      default: grant_o = M_IFU;
    endcase
  end

endmodule

// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter
//   Shares one simple-bus memory port between instruction fetch (m0) and
//   the load/store unit (m1). Arbitration is combinational in IDLE, the
//   grant is locked until memory accepts, and the response comes back to
//   the issuing master in the cycle after acceptance.
//   Ports:
//     clock, reset (synchronous, active-low)
//     mX_req_*  : master request channel (valid/ready, addr, writeEn, size, wdata)
//     mX_resp_* : one-cycle response pulse with read data
//     mem_*     : request channel to memory; mem_rdata arrives the cycle
//                 after mem_valid && mem_ready
module simple_bus_arbiter
  import simple_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic              m0_req_writeEn,
  input  logic [2:0]        m0_req_size,
  input  logic [DATA_W-1:0] m0_req_wdata,
  output logic              m0_resp_valid,
  output logic [DATA_W-1:0] m0_resp_rdata,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic              m1_req_writeEn,
  input  logic [2:0]        m1_req_size,
  input  logic [DATA_W-1:0] m1_req_wdata,
  output logic              m1_resp_valid,
  output logic [DATA_W-1:0] m1_resp_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_writeEn,
  output logic [2:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              writeEn;
    logic [2:0]        size;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;

  logic   pick_s, pick_valid_s;
  logic   sel_s;
  logic   issue_s;
  logic   accept_s;
  logic   resp_s;
  logic   mem_valid_s;
  req_t   sel_req_s;

  rr_pick2 u_pick (
    .req_i         ({m1_req_valid, m0_req_valid}),
    .last_i        (last_q),
    .rr_en_i       (RR_EN),
    .grant_o       (pick_s),
    .grant_valid_o (pick_valid_s)
  );

  // Next-state logic: arbitrate in IDLE, hold the locked grant in WAIT.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    sel_s    = owner_q;
    issue_s  = 1'b0;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid_s) begin
          sel_s   = pick_s;
          issue_s = 1'b1;
          owner_d = pick_s;
          if (mem_ready) begin
            accept_s = 1'b1;
            last_d   = pick_s;
            state_d  = S_RESP;
          end else begin
            // 'last' only moves on acceptance so a stalled grant does not
            // cost the other master its turn.
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Owner keeps the bus even if it drops valid mid-stall.
        issue_s = 1'b1;
        if (mem_ready) begin
          accept_s = 1'b1;
          last_d   = owner_q;
          state_d  = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, owner and round-robin history registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= M_IFU;
      last_q  <= M_LSU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Selected master's request bundle.
  always_comb begin
    if (sel_s == M_LSU) begin
      sel_req_s = '{addr: m1_req_addr, writeEn: m1_req_writeEn,
                    size: m1_req_size, wdata: m1_req_wdata};
    end else begin
      sel_req_s = '{addr: m0_req_addr, writeEn: m0_req_writeEn,
                    size: m0_req_size, wdata: m0_req_wdata};
    end
  end

  assign resp_s      = (state_q == S_RESP);
  // Everything is forced quiet while reset is low, so a response pending
  // at reset never leaks out in the reset cycle.
  assign mem_valid_s = issue_s & reset;

  // Memory-side outputs; fields are zero whenever no request is issued.
  always_comb begin
    mem_valid = mem_valid_s;
    if (mem_valid_s) begin
      mem_addr    = sel_req_s.addr;
      mem_writeEn = sel_req_s.writeEn;
      mem_size    = sel_req_s.size;
      mem_wdata   = sel_req_s.wdata;
    end else begin
      mem_addr    = {ADDR_W{1'b0}};
      mem_writeEn = 1'b0;
      mem_size    = 3'd0;
      mem_wdata   = {DATA_W{1'b0}};
    end
  end

  // Master-side handshake and response routing.
  always_comb begin
    m0_req_ready  = reset & accept_s & (sel_s == M_IFU);
    m1_req_ready  = reset & accept_s & (sel_s == M_LSU);
    m0_resp_valid = reset & resp_s & (owner_q == M_IFU);
    m1_resp_valid = reset & resp_s & (owner_q == M_LSU);
    if (m0_resp_valid) begin
      m0_resp_rdata = mem_rdata;
    end else begin
      m0_resp_rdata = {DATA_W{1'b0}};
    end
    if (m1_resp_valid) begin
      m1_resp_rdata = mem_rdata;
    end else begin
      m1_resp_rdata = {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter
//   Directed bench driving two arbiter instances from shared stimulus:
//   dut_rr (RR_EN=1) and dut_fp (RR_EN=0, fixed priority to m1).
module tb_simple_bus_arbiter;

  logic        clock;
  logic        reset;
  logic        m0_req_valid, m1_req_valid;
  logic [31:0] m0_req_addr,  m1_req_addr;
  logic        m0_req_writeEn, m1_req_writeEn;
  logic [2:0]  m0_req_size,  m1_req_size;
  logic [31:0] m0_req_wdata, m1_req_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        rr_m0_req_ready, rr_m1_req_ready, rr_m0_resp_valid, rr_m1_resp_valid;
  logic [31:0] rr_m0_resp_rdata, rr_m1_resp_rdata;
  logic        rr_mem_valid, rr_mem_writeEn;
  logic [31:0] rr_mem_addr, rr_mem_wdata;
  logic [2:0]  rr_mem_size;

  logic        fp_m0_req_ready, fp_m1_req_ready, fp_m0_resp_valid, fp_m1_resp_valid;
  logic [31:0] fp_m0_resp_rdata, fp_m1_resp_rdata;
  logic        fp_mem_valid, fp_mem_writeEn;
  logic [31:0] fp_mem_addr, fp_mem_wdata;
  logic [2:0]  fp_mem_size;

  int checks   = 0;
  int failures = 0;

  simple_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut_rr (
    .clock(clock), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(rr_m0_req_ready),
    .m0_req_addr(m0_req_addr), .m0_req_writeEn(m0_req_writeEn),
    .m0_req_size(m0_req_size), .m0_req_wdata(m0_req_wdata),
    .m0_resp_valid(rr_m0_resp_valid), .m0_resp_rdata(rr_m0_resp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(rr_m1_req_ready),
    .m1_req_addr(m1_req_addr), .m1_req_writeEn(m1_req_writeEn),
    .m1_req_size(m1_req_size), .m1_req_wdata(m1_req_wdata),
    .m1_resp_valid(rr_m1_resp_valid), .m1_resp_rdata(rr_m1_resp_rdata),
    .mem_valid(rr_mem_valid), .mem_ready(mem_ready), .mem_addr(rr_mem_addr),
    .mem_writeEn(rr_mem_writeEn), .mem_size(rr_mem_size),
    .mem_wdata(rr_mem_wdata), .mem_rdata(mem_rdata)
  );

  simple_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clock(clock), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(fp_m0_req_ready),
    .m0_req_addr(m0_req_addr), .m0_req_writeEn(m0_req_writeEn),
    .m0_req_size(m0_req_size), .m0_req_wdata(m0_req_wdata),
    .m0_resp_valid(fp_m0_resp_valid), .m0_resp_rdata(fp_m0_resp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(fp_m1_req_ready),
    .m1_req_addr(m1_req_addr), .m1_req_writeEn(m1_req_writeEn),
    .m1_req_size(m1_req_size), .m1_req_wdata(m1_req_wdata),
    .m1_resp_valid(fp_m1_resp_valid), .m1_resp_rdata(fp_m1_resp_rdata),
    .mem_valid(fp_mem_valid), .mem_ready(mem_ready), .mem_addr(fp_mem_addr),
    .mem_writeEn(fp_mem_writeEn), .mem_size(fp_mem_size),
    .mem_wdata(fp_mem_wdata), .mem_rdata(mem_rdata)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then changed and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    m0_req_addr = 32'h0; m1_req_addr = 32'h0;
    m0_req_writeEn = 1'b0; m1_req_writeEn = 1'b0;
    m0_req_size = 3'd0; m1_req_size = 3'd0;
    m0_req_wdata = 32'h0; m1_req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    logic exp_m;
    reset = 1'b0;
    idle_inputs();
    tick(); tick();

    // ---- reset state: outputs quiet even with a request present
    m0_req_valid = 1'b1; m0_req_addr = 32'h1234; mem_ready = 1'b1;
    settle();
    chk("rst_mem_valid_rr", {63'd0, rr_mem_valid}, 64'd0);
    chk("rst_mem_valid_fp", {63'd0, fp_mem_valid}, 64'd0);
    chk("rst_m0_ready", {63'd0, rr_m0_req_ready}, 64'd0);
    chk("rst_mem_addr", {32'd0, rr_mem_addr}, 64'd0);
    idle_inputs();
    tick();
    reset = 1'b1;

    // ---- m0 alone reads 0x80000000
    m0_req_valid = 1'b1; m0_req_addr = 32'h8000_0000; m0_req_size = 3'd2;
    mem_ready = 1'b1;
    settle();
    chk("rd_m0_ready", {63'd0, rr_m0_req_ready}, 64'd1);
    chk("rd_m1_ready", {63'd0, rr_m1_req_ready}, 64'd0);
    chk("rd_mem_valid", {63'd0, rr_mem_valid}, 64'd1);
    chk("rd_mem_addr", {32'd0, rr_mem_addr}, 64'h8000_0000);
    chk("rd_mem_size", {61'd0, rr_mem_size}, 64'd2);
    chk("rd_fp_m0_ready", {63'd0, fp_m0_req_ready}, 64'd1);
    tick();
    idle_inputs();
    mem_rdata = 32'h0000_0013;
    settle();
    chk("rd_m0_resp_valid", {63'd0, rr_m0_resp_valid}, 64'd1);
    chk("rd_m0_resp_rdata", {32'd0, rr_m0_resp_rdata}, 64'h13);
    chk("rd_m1_resp_valid", {63'd0, rr_m1_resp_valid}, 64'd0);
    chk("rd_m1_resp_rdata", {32'd0, rr_m1_resp_rdata}, 64'd0);
    chk("rd_resp_mem_valid", {63'd0, rr_mem_valid}, 64'd0);
    tick();
    chk("rd_resp_one_cycle", {63'd0, rr_m0_resp_valid}, 64'd0);

    // ---- fresh reset, then both request every cycle
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m0_req_valid = 1'b1; m0_req_addr = 32'h0000_0100;
    m1_req_valid = 1'b1; m1_req_addr = 32'h0000_0200;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_rdata = 32'hA000_0000 + i;
      settle();
      exp_m = ((i / 2) % 2) == 1;
      if ((i % 2) == 0) begin
        chk($sformatf("rr_m0_ready_%0d", i), {63'd0, rr_m0_req_ready}, {63'd0, ~exp_m});
        chk($sformatf("rr_m1_ready_%0d", i), {63'd0, rr_m1_req_ready}, {63'd0, exp_m});
        chk($sformatf("rr_addr_%0d", i), {32'd0, rr_mem_addr},
            exp_m ? 64'h200 : 64'h100);
        chk($sformatf("fp_m1_ready_%0d", i), {63'd0, fp_m1_req_ready}, 64'd1);
        chk($sformatf("fp_m0_ready_%0d", i), {63'd0, fp_m0_req_ready}, 64'd0);
      end else begin
        chk($sformatf("rr_gap_valid_%0d", i), {63'd0, rr_mem_valid}, 64'd0);
        chk($sformatf("rr_m0_resp_%0d", i), {63'd0, rr_m0_resp_valid}, {63'd0, ~exp_m});
        chk($sformatf("rr_m1_resp_%0d", i), {63'd0, rr_m1_resp_valid}, {63'd0, exp_m});
        chk($sformatf("rr_rdata_%0d", i),
            {32'd0, (exp_m ? rr_m1_resp_rdata : rr_m0_resp_rdata)},
            {32'd0, 32'hA000_0000 + i});
        chk($sformatf("fp_m1_resp_%0d", i), {63'd0, fp_m1_resp_valid}, 64'd1);
        chk($sformatf("fp_m0_ready_gap_%0d", i), {63'd0, fp_m0_req_ready}, 64'd0);
      end
      tick();
    end
    idle_inputs();
    tick();

    // ---- m1 write stalled 3 cycles while m0 waits
    m1_req_valid = 1'b1; m1_req_addr = 32'h8000_1000; m1_req_writeEn = 1'b1;
    m1_req_size = 3'd2; m1_req_wdata = 32'hDEAD_BEEF;
    mem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c >= 2) begin
        m0_req_valid = 1'b1; m0_req_addr = 32'h8000_0004;
      end
      mem_ready = (c == 4);
      settle();
      chk($sformatf("wr_addr_c%0d", c), {32'd0, rr_mem_addr}, 64'h8000_1000);
      chk($sformatf("wr_wdata_c%0d", c), {32'd0, rr_mem_wdata}, 64'hDEAD_BEEF);
      chk($sformatf("wr_we_c%0d", c), {63'd0, rr_mem_writeEn}, 64'd1);
      chk($sformatf("wr_m1_ready_c%0d", c), {63'd0, rr_m1_req_ready}, (c == 4) ? 64'd1 : 64'd0);
      chk($sformatf("wr_m0_ready_c%0d", c), {63'd0, rr_m0_req_ready}, 64'd0);
      tick();
    end
    m1_req_valid = 1'b0; m1_req_writeEn = 1'b0;
    mem_rdata = 32'h0000_0055; mem_ready = 1'b1;
    settle();
    chk("wr_m1_resp_valid", {63'd0, rr_m1_resp_valid}, 64'd1);
    chk("wr_m1_resp_rdata", {32'd0, rr_m1_resp_rdata}, 64'h55);
    chk("wr_m0_resp_valid", {63'd0, rr_m0_resp_valid}, 64'd0);
    chk("wr_resp_mem_valid", {63'd0, rr_mem_valid}, 64'd0);
    tick();
    settle();
    chk("wr_m0_after_ready", {63'd0, rr_m0_req_ready}, 64'd1);
    chk("wr_m0_after_addr", {32'd0, rr_mem_addr}, 64'h8000_0004);
    tick();
    idle_inputs();
    tick();

    // ---- reset while in WAIT
    m0_req_valid = 1'b1; m0_req_addr = 32'h0000_0040; mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    settle();
    chk("rstw_gated_valid", {63'd0, rr_mem_valid}, 64'd0);
    tick();
    reset = 1'b1;
    m0_req_valid = 1'b0; mem_ready = 1'b1;
    settle();
    chk("rstw_idle_valid", {63'd0, rr_mem_valid}, 64'd0);
    chk("rstw_no_resp", {63'd0, rr_m0_resp_valid}, 64'd0);
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    m0_req_addr = 32'h0000_0100; m1_req_addr = 32'h0000_0200;
    settle();
    chk("rstw_tie_m0", {63'd0, rr_m0_req_ready}, 64'd1);
    chk("rstw_tie_not_m1", {63'd0, rr_m1_req_ready}, 64'd0);
    tick();
    idle_inputs();
    tick();

    // ---- reset while in RESP
    m1_req_valid = 1'b1; m1_req_addr = 32'h0000_0300; mem_ready = 1'b1;
    settle();
    chk("rstr_m1_ready", {63'd0, rr_m1_req_ready}, 64'd1);
    tick();
    m1_req_valid = 1'b0; mem_rdata = 32'h0000_0077;
    reset = 1'b0;
    settle();
    chk("rstr_no_resp_in_reset", {63'd0, rr_m1_resp_valid}, 64'd0);
    tick();
    reset = 1'b1;
    settle();
    chk("rstr_no_resp_after", {63'd0, rr_m1_resp_valid}, 64'd0);
    chk("rstr_mem_valid", {63'd0, rr_mem_valid}, 64'd0);
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    settle();
    chk("rstr_tie_m0", {63'd0, rr_m0_req_ready}, 64'd1);
    tick();
    idle_inputs();
    tick();

    // ---- idle bus: request fields wiggle but valid is low
    m0_req_addr = 32'hFFFF_FFFF; m0_req_wdata = 32'h1234_5678; m0_req_size = 3'd2;
    m1_req_addr = 32'hAAAA_AAAA; m1_req_writeEn = 1'b1; m1_req_size = 3'd1;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk($sformatf("idle_bus_%0d", k),
          {rr_mem_valid, rr_mem_writeEn, rr_mem_size, rr_mem_addr, rr_mem_wdata[26:0]}, 64'd0);
      chk($sformatf("idle_wdata_%0d", k), {32'd0, rr_mem_wdata}, 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
